// File: rtl/mem_bank_pkg.sv
// Shared types and helpers for the mem_bank_rf register file and its clear sequencer.
package mem_bank_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_e;

    function automatic int lanes_of(input int width, input int lane_w);
        return width / lane_w;
    endfunction

endpackage

// File: rtl/mem_clear_fsm.sv
// Bulk-clear sequencer: walks every word once, emitting a zero-write strobe per cycle.
module mem_clear_fsm
    import mem_bank_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_start,
    output logic                  busy,
    output logic                  clr_done,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    clr_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy     = 1'b0;
        clr_done = 1'b0;
        clr_we   = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_start) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                busy   = 1'b1;
                clr_we = 1'b1;
                // Counter parks at zero after the last word so it never wraps past DEPTH-1.
                if (cnt_q == LAST_ADDR) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                clr_done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign clr_addr = cnt_q;

endmodule

// File: rtl/mem_bank_rf.sv
// Lane-masked register file with registered read, write-first bypass and hardware bulk clear.
module mem_bank_rf
    import mem_bank_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 8,
    parameter int LANE_W     = 8,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int LANES      = lanes_of(WIDTH, LANE_W)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [LANES-1:0]      wmask,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata,
    output logic                  rvalid,
    input  logic                  clr_start,
    output logic                  busy,
    output logic                  clr_done
);

    // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [WIDTH-1:0]      lane_bits;
    logic [WIDTH-1:0]      wr_word;
    logic [WIDTH-1:0]      rd_word;
    logic [WIDTH-1:0]      rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  waddr_ok, raddr_ok;
    logic                  port_we, port_re;

    mem_clear_fsm #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear_fsm (
        .clk       (clk),
        .rst       (rst),
        .clr_start (clr_start),
        .busy      (busy),
        .clr_done  (clr_done),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr)
    );

    assign waddr_ok = {1'b0, waddr} < DEPTH_W;
    assign raddr_ok = {1'b0, raddr} < DEPTH_W;
    assign port_we  = we && !busy && waddr_ok;
    assign port_re  = re && !busy;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign lane_bits[gi*LANE_W +: LANE_W] = {LANE_W{wmask[gi]}};
    end

    assign wr_word = (mem_q[waddr] & ~lane_bits) | (wdata & lane_bits);

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
        logic [WIDTH-1:0] word_q, word_d;

        always_comb begin
            word_d = word_q;
            if (clr_we && clr_addr == ADDR_WIDTH'(gi)) begin
                word_d = '0;
            end else if (port_we && waddr == ADDR_WIDTH'(gi)) begin
                word_d = wr_word;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                word_q <= '0;
            end else begin
                word_q <= word_d;
            end
        end

        assign mem_q[gi] = word_q;
    end

    // Write-first: a same-address write in the read cycle is returned already merged.
    always_comb begin
        rd_word = '0;
        if (raddr_ok) begin
            rd_word = (port_we && waddr == raddr) ? wr_word : mem_q[raddr];
        end
    end

    always_comb begin
        rvalid_d = port_re;
        rdata_d  = port_re ? rd_word : rdata_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;

endmodule

// File: tb/tb_mem_bank_rf.sv
// Directed self-checking bench for mem_bank_rf (DEPTH=8 main instance plus a DEPTH=6 instance).
module tb_mem_bank_rf;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic        clr_start = 1'b0;
    logic [2:0]  waddr = '0;
    logic [2:0]  raddr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wmask = '0;

    logic [31:0] rdata, rdata6;
    logic        rvalid, busy, clr_done;
    logic        rvalid6, busy6, clr_done6;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_bank_rf u_dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wmask(wmask),
        .re(re), .raddr(raddr), .rdata(rdata), .rvalid(rvalid),
        .clr_start(clr_start), .busy(busy), .clr_done(clr_done)
    );

    mem_bank_rf #(.DEPTH(6)) u_dut6 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wmask(wmask),
        .re(re), .raddr(raddr), .rdata(rdata6), .rvalid(rvalid6),
        .clr_start(clr_start), .busy(busy6), .clr_done(clr_done6)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] m);
        we = 1'b1; waddr = a; wdata = d; wmask = m;
        tick();
        we = 1'b0;
    endtask

    task automatic do_read(input logic [2:0] a);
        re = 1'b1; raddr = a;
        tick();
        re = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected %h", rdata, 32'h0); end
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected 0", rvalid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (clr_done !== 1'b0) begin errors++; $display("FAIL reset_clr_done: got %b expected 0", clr_done); end
        @(negedge clk);
        rst = 1'b1;
        tick();
        $display("reset released");
    endtask

    task automatic test_read_all();
        for (int a = 0; a < 8; a++) begin
            do_read(3'(a));
            checks++;
            if (rvalid !== 1'b1 || rdata !== 32'h0) begin
                errors++; $display("FAIL read_all[%0d]: got rvalid=%b rdata=%h expected rvalid=1 rdata=00000000", a, rvalid, rdata);
            end
            $display("read addr %0d -> %h", a, rdata);
        end
        tick();
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL idle_rvalid: got %b expected 0", rvalid); end
    endtask

    task automatic test_mask_write();
        do_write(3'd3, 32'hDEADBEEF, 4'hF);
        do_write(3'd3, 32'h000000AA, 4'h1);
        do_read(3'd3);
        checks++; if (rdata !== 32'hDEADBEAA || rvalid !== 1'b1) begin errors++; $display("FAIL mask_merge: got %h/%b expected deadbeaa/1", rdata, rvalid); end
        $display("masked write addr 3 -> %h", rdata);
        do_write(3'd3, 32'h11111111, 4'h0);
        do_read(3'd3);
        checks++; if (rdata !== 32'hDEADBEAA) begin errors++; $display("FAIL mask_zero: got %h expected deadbeaa", rdata); end
        tick();
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL hold_rvalid: got %b expected 0", rvalid); end
        checks++; if (rdata !== 32'hDEADBEAA) begin errors++; $display("FAIL hold_rdata: got %h expected deadbeaa", rdata); end
    endtask

    task automatic test_bypass();
        we = 1'b1; waddr = 3'd5; wdata = 32'h12345678; wmask = 4'hC;
        re = 1'b1; raddr = 3'd5;
        tick();
        we = 1'b0; re = 1'b0;
        checks++; if (rdata !== 32'h12340000 || rvalid !== 1'b1) begin errors++; $display("FAIL bypass: got %h/%b expected 12340000/1", rdata, rvalid); end
        $display("bypass read addr 5 -> %h", rdata);
        do_read(3'd5);
        checks++; if (rdata !== 32'h12340000) begin errors++; $display("FAIL bypass_stored: got %h expected 12340000", rdata); end
    endtask

    task automatic test_oob();
        logic [31:0] exp6 [6];
        exp6 = '{32'h0, 32'h0, 32'h0, 32'hDEADBEAA, 32'h0, 32'h12340000};
        do_write(3'd6, 32'hFFFFFFFF, 4'hF);
        do_write(3'd7, 32'hFFFFFFFF, 4'hF);
        do_read(3'd6);
        checks++; if (rdata6 !== 32'h0 || rvalid6 !== 1'b1) begin errors++; $display("FAIL oob_read6: got %h/%b expected 00000000/1", rdata6, rvalid6); end
        checks++; if (rdata !== 32'hFFFFFFFF) begin errors++; $display("FAIL depth8_read6: got %h expected ffffffff", rdata); end
        $display("oob read addr 6 -> depth6 %h depth8 %h", rdata6, rdata);
        for (int a = 0; a < 6; a++) begin
            do_read(3'(a));
            checks++;
            if (rdata6 !== exp6[a]) begin errors++; $display("FAIL oob_intact[%0d]: got %h expected %h", a, rdata6, exp6[a]); end
        end
    endtask

    task automatic test_clear();
        for (int a = 0; a < 8; a++) do_write(3'(a), 32'hA5A50000 | 32'(a + 1), 4'hF);
        clr_start = 1'b1;
        tick();
        // Held request plus port traffic while busy must all be ignored.
        we = 1'b1; waddr = 3'd0; wdata = 32'hFFFFFFFF; wmask = 4'hF;
        re = 1'b1; raddr = 3'd1;
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (busy !== 1'b1 || rvalid !== 1'b0 || clr_done !== 1'b0) begin
                errors++; $display("FAIL clear_cycle[%0d]: got busy=%b rvalid=%b done=%b expected 1/0/0", c, busy, rvalid, clr_done);
            end
            tick();
        end
        we = 1'b0; re = 1'b0; clr_start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL done_busy: got %b expected 0", busy); end
        checks++; if (clr_done !== 1'b1) begin errors++; $display("FAIL done_pulse: got %b expected 1", clr_done); end
        tick();
        checks++; if (clr_done !== 1'b0) begin errors++; $display("FAIL done_width: got %b expected 0", clr_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
        for (int a = 0; a < 8; a++) begin
            do_read(3'(a));
            checks++;
            if (rdata !== 32'h0 || rvalid !== 1'b1) begin errors++; $display("FAIL cleared[%0d]: got %h/%b expected 00000000/1", a, rdata, rvalid); end
            $display("post-clear read addr %0d -> %h", a, rdata);
        end
    endtask

    task automatic test_reset_mid_clear();
        for (int a = 0; a < 8; a++) do_write(3'(a), 32'h5A5A0000 | 32'(a + 1), 4'hF);
        do_read(3'd7);
        checks++; if (rdata !== 32'h5A5A0008) begin errors++; $display("FAIL prefill_read7: got %h expected 5a5a0008", rdata); end
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        tick();
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midclear_busy: got %b expected 1", busy); end
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b expected 0", busy); end
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL arst_rvalid: got %b expected 0", rvalid); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL arst_rdata: got %h expected 00000000", rdata); end
        #2;
        rst = 1'b1;
        tick();
        for (int a = 0; a < 8; a++) begin
            do_read(3'(a));
            checks++;
            if (rdata !== 32'h0 || rvalid !== 1'b1) begin errors++; $display("FAIL arst_word[%0d]: got %h/%b expected 00000000/1", a, rdata, rvalid); end
            $display("post-reset read addr %0d -> %h", a, rdata);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_read_all();
        test_mask_write();
        test_bypass();
        test_oob();
        test_clear();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bank_rf.md
Name: mem_bank_rf

Overview:
Parametrised register-file memory for the CPU datapath: DEPTH words of WIDTH bits, one write port with lane masks and one registered read port.
Adds a hardware bulk-clear sequencer that zeroes the array one word per cycle without CPU involvement.
Generalises the fixed 8-entry, unmasked, combinational-read memory; sits between the control unit and the ALU/register path.

Parameters:
WIDTH, 32, data word width in bits; must be a multiple of LANE_W
DEPTH, 8, number of words; any value >= 2, need not be a power of two
LANE_W, 8, bits per write-mask lane; LANES = WIDTH/LANE_W
ADDR_WIDTH, $clog2(DEPTH), address width (derived, not overridden)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low
we  input  1  write enable
waddr  input  ADDR_WIDTH  write address
wdata  input  WIDTH  write data
wmask  input  LANES  per-lane write enable; bit i covers wdata[i*LANE_W +: LANE_W]
re  input  1  read request
raddr  input  ADDR_WIDTH  read address
rdata  output  WIDTH  registered read data
rvalid  output  1  rdata valid for one cycle
clr_start  input  1  request bulk clear (single-cycle pulse or level)
busy  output  1  clear in progress; port accesses ignored
clr_done  output  1  one-cycle pulse after last word cleared

Behaviour:
- Reset (rst=0, async): every array word = 0, rdata = 0, rvalid = 0, busy = 0, clr_done = 0, FSM = IDLE, clear counter = 0.
- Write: at rising edge with we=1, busy=0, waddr < DEPTH: lanes with wmask[i]=1 take wdata lane; other lanes unchanged. wmask=0 -> no change.
- Write to waddr >= DEPTH: silently dropped.
- Read: re=1, busy=0 at edge N -> rdata/rvalid=1 at edge N (visible in cycle N+1); latency 1. re=0 -> rvalid=0, rdata holds last value.
- raddr >= DEPTH: rvalid=1, rdata=0.
- Same-cycle read and write to same address: write-first; rdata = merged word (masked new lanes, old lanes elsewhere).
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE: clr_start=1 -> CLEAR, counter=0, busy=1 next cycle. The request cycle's own we/re are still served (busy=0 in that cycle).
  - CLEAR: each cycle write 0 to word[counter], counter++; when counter == DEPTH-1, go to DONE. Takes exactly DEPTH cycles.
  - DONE: clr_done=1 for one cycle, busy=0 in that cycle, -> IDLE.
  - clr_start while CLEAR or DONE: ignored, no restart.
- busy=1: we and re ignored; rvalid=0; rdata holds.
- Async reset mid-clear: immediate return to reset state; all words zero regardless of progress.
- Counter width ADDR_WIDTH; no wrap beyond DEPTH-1.

Decomposition:
- Package mem_bank_pkg: clear-state enum {IDLE, CLEAR, DONE}, 2-bit encoding; LANES derivation helper function.
- Sub-module mem_clear_fsm: owns state, counter, busy, clr_done; outputs clear-write strobe and address to the array.
- Array, mask merge, bypass and read register stay in mem_bank_rf.

Test Plan:
- Reset then read all addresses 0..7 -> rvalid=1 one cycle after each re, rdata=0.
- Write 0xDEADBEEF @3 wmask=4'hF, then write 0x000000AA @3 wmask=4'h1; read 3 -> 0xDEADBEAA.
- Same cycle we=1 waddr=5 wdata=0x12345678 wmask=4'hC and re=1 raddr=5 (word5 previously 0) -> next-cycle rdata=0x12340000.
- DEPTH=6: write 0xFFFFFFFF @6 and @7, read @6 -> rdata=0, rvalid=1; words 0..5 unchanged.
- Fill all 8 words nonzero, pulse clr_start -> busy=1 for exactly 8 cycles, clr_done pulse on cycle 9; we/re during busy ignored, rvalid=0; reads afterwards all 0.
- Assert rst=0 at clear cycle 3 with words 4..7 nonzero -> busy=0, rvalid=0 immediately; all words read 0 after release.
